// File: rtl/write_data.sv
// Frame sink: captures an even/odd pixel-pair stream into a bottom-up R,G,B frame buffer,
// then drains the buffer as a byte stream over valid/ready and pulses write_done.
module write_data #(
    parameter int IMAGE_WIDTH  = 768,
    parameter int IMAGE_HEIGHT = 512
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vertical_Pulse,
    input  logic       horizontal_Pulse,
    input  logic [7:0] data_Red_Even,
    input  logic [7:0] data_Green_Even,
    input  logic [7:0] data_Blue_Even,
    input  logic [7:0] data_Red_Odd,
    input  logic [7:0] data_Green_Odd,
    input  logic [7:0] data_Blue_Odd,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_error,
    output logic       write_done
);

    localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT * 3;
    localparam int RW = $clog2(IMAGE_HEIGHT + 1);
    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int AW = $clog2(IMAGE_SIZE + 1);

    localparam logic [RW-1:0] LAST_ROW  = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(IMAGE_WIDTH - 2);
    localparam logic [AW-1:0] ROW_BYTES = AW'(IMAGE_WIDTH * 3);
    localparam logic [AW-1:0] LAST_ADDR = AW'(IMAGE_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        CAPTURE,
        DUMP,
        DONE
    } state_t;

    state_t        state_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [AW-1:0] dump_q;
    logic          out_valid_q;
    logic          write_done_q;
    logic          frame_error_q;

    logic [7:0]    frame_mem [IMAGE_SIZE];
    logic [AW-1:0] wr_base;
    logic          pair_we;

    // Rows land bottom-up: image row 0 occupies the last ROW_BYTES of the buffer.
    always_comb begin
        wr_base = ROW_BYTES * AW'(LAST_ROW - row_q) + AW'(3) * AW'(col_q);
        pair_we = (state_q == CAPTURE) && horizontal_Pulse && !vertical_Pulse;
    end

    // Buffer is deliberately not reset; it is fully rewritten by every completed frame.
    always_ff @(posedge clk) begin
        if (pair_we) begin
            frame_mem[wr_base]          <= data_Red_Even;
            frame_mem[wr_base + AW'(1)] <= data_Green_Even;
            frame_mem[wr_base + AW'(2)] <= data_Blue_Even;
            frame_mem[wr_base + AW'(3)] <= data_Red_Odd;
            frame_mem[wr_base + AW'(4)] <= data_Green_Odd;
            frame_mem[wr_base + AW'(5)] <= data_Blue_Odd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            row_q         <= '0;
            col_q         <= '0;
            dump_q        <= '0;
            out_valid_q   <= 1'b0;
            write_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            write_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (vertical_Pulse) state_q <= VSYNC;
                end
                VSYNC: begin
                    if (!vertical_Pulse) begin
                        state_q <= CAPTURE;
                        row_q   <= '0;
                        col_q   <= '0;
                    end
                end
                CAPTURE: begin
                    if (vertical_Pulse) begin
                        frame_error_q <= 1'b1;
                        state_q       <= VSYNC;
                        row_q         <= '0;
                        col_q         <= '0;
                    end else if (horizontal_Pulse) begin
                        if (col_q == LAST_COL) begin
                            col_q <= '0;
                            row_q <= row_q + RW'(1);
                            if (row_q == LAST_ROW) begin
                                state_q     <= DUMP;
                                out_valid_q <= 1'b1;
                                dump_q      <= '0;
                            end
                        end else begin
                            col_q <= col_q + CW'(2);
                        end
                    end
                end
                DUMP: begin
                    if (horizontal_Pulse) frame_error_q <= 1'b1;
                    if (out_ready) begin
                        if (dump_q == LAST_ADDR) begin
                            state_q      <= DONE;
                            out_valid_q  <= 1'b0;
                            write_done_q <= 1'b1;
                        end else begin
                            dump_q <= dump_q + AW'(1);
                        end
                    end
                end
                DONE: begin
                    if (horizontal_Pulse) frame_error_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_byte    = out_valid_q ? frame_mem[dump_q] : '0;
    assign out_valid   = out_valid_q;
    assign write_done  = write_done_q;
    assign frame_error = frame_error_q;

endmodule
